// File: rtl/century_pkg.sv
// Shared constants and types for the century_clock display scanner.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package century_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [2:0] SLOT_SEC_U  = 3'd0;
  localparam logic [2:0] SLOT_SEC_T  = 3'd1;
  localparam logic [2:0] SLOT_MIN_U  = 3'd2;
  localparam logic [2:0] SLOT_MIN_T  = 3'd3;
  localparam logic [2:0] SLOT_HOUR_U = 3'd4;
  localparam logic [2:0] SLOT_HOUR_T = 3'd5;
  localparam logic [2:0] SLOT_DAY_U  = 3'd6;
  localparam logic [2:0] SLOT_DAY_T  = 3'd7;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
  import century_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg_n
);

  always_comb begin
    case (i_bcd)
      4'd0:    o_seg_n = SEG_0;
      4'd1:    o_seg_n = SEG_1;
      4'd2:    o_seg_n = SEG_2;
      4'd3:    o_seg_n = SEG_3;
      4'd4:    o_seg_n = SEG_4;
      4'd5:    o_seg_n = SEG_5;
      4'd6:    o_seg_n = SEG_6;
      4'd7:    o_seg_n = SEG_7;
      4'd8:    o_seg_n = SEG_8;
      4'd9:    o_seg_n = SEG_9;
      default: o_seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/century_display_scan.sv
// Multiplexed 8-digit common-anode scanner for the century_clock digit bus.
// Digits are snapshotted once per frame so a rollover never displays torn values.
module century_display_scan
  import century_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_blank_lz,
  input  logic [3:0] i_sec_unit,
  input  logic [3:0] i_sec_ten,
  input  logic [3:0] i_min_unit,
  input  logic [3:0] i_min_ten,
  input  logic [3:0] i_hour_unit,
  input  logic [3:0] i_hour_ten,
  input  logic [3:0] i_day_unit,
  input  logic [1:0] i_day_ten,
  output logic [6:0] o_seg_n,
  output logic [7:0] o_dig_n,
  output logic       o_dp_n,
  output logic       o_frame_done
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  scan_state_t                    r_state;
  logic [2:0]                     r_idx;
  logic [CNT_W-1:0]               r_cnt;
  logic [NUM_DIGITS-1:0][3:0]     r_snap;

  scan_state_t                    w_state_nxt;
  logic [2:0]                     w_idx_nxt;
  logic [CNT_W-1:0]               w_cnt_nxt;
  logic                           w_frame_end;
  logic                           w_capture;
  logic [NUM_DIGITS-1:0][3:0]     w_inputs;
  logic [NUM_DIGITS-1:0][3:0]     w_snap_nxt;
  logic [3:0]                     w_digit;
  logic [6:0]                     w_dec_seg;
  logic [6:0]                     w_seg_nxt;
  logic [7:0]                     w_dig_nxt;
  logic                           w_dp_nxt;
  logic                           w_lz_hide;

  assign w_inputs = {{2'b00, i_day_ten}, i_day_unit, i_hour_ten, i_hour_unit,
                     i_min_ten, i_min_unit, i_sec_ten, i_sec_unit};

  // Capture happens only in the very first cycle of a frame.
  assign w_capture  = i_en && (r_state == BLANK) && (r_idx == 3'd0) && (r_cnt == '0);
  assign w_snap_nxt = w_capture ? w_inputs : r_snap;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_frame_end = 1'b0;
    if (!i_en) begin
      w_state_nxt = BLANK;
      w_idx_nxt   = 3'd0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_nxt = ON;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          if (r_cnt == SCAN_LAST) begin
            w_state_nxt = BLANK;
            w_idx_nxt   = r_idx + 3'd1;
            w_cnt_nxt   = '0;
            w_frame_end = (r_idx == SLOT_DAY_T);
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign w_digit = w_snap_nxt[w_idx_nxt];

  bcd_to_seg7 u_dec (
    .i_bcd   (w_digit),
    .o_seg_n (w_dec_seg)
  );

  assign w_lz_hide = (w_idx_nxt == SLOT_DAY_T) && i_blank_lz &&
                     (w_snap_nxt[SLOT_DAY_T] == 4'd0);

  // Outputs are derived from next-state so they line up with the registered FSM.
  always_comb begin
    w_seg_nxt = SEG_OFF;
    w_dig_nxt = 8'hFF;
    w_dp_nxt  = 1'b1;
    if (w_state_nxt == ON) begin
      if (!w_lz_hide) begin
        w_dig_nxt = ~(8'd1 << w_idx_nxt);
        w_seg_nxt = w_dec_seg;
      end
      if ((w_idx_nxt == SLOT_MIN_U) || (w_idx_nxt == SLOT_HOUR_U)) begin
        w_dp_nxt = w_snap_nxt[SLOT_SEC_U][0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= BLANK;
      r_idx        <= 3'd0;
      r_cnt        <= '0;
      r_snap       <= '0;
      o_seg_n      <= SEG_OFF;
      o_dig_n      <= 8'hFF;
      o_dp_n       <= 1'b1;
      o_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_snap       <= w_snap_nxt;
      o_seg_n      <= w_seg_nxt;
      o_dig_n      <= w_dig_nxt;
      o_dp_n       <= w_dp_nxt;
      o_frame_done <= w_frame_end;
    end
  end

endmodule

// File: tb/tb_century_display_scan.sv
// Directed bench for century_display_scan with SCAN_DIV=4, BLANK_CYC=2 (48-cycle frame).
module tb_century_display_scan;

  logic       clk;
  logic       rst;
  logic       en;
  logic       blank_lz;
  logic [3:0] sec_unit, sec_ten, min_unit, min_ten, hour_unit, hour_ten, day_unit;
  logic [1:0] day_ten;
  logic [6:0] seg_n;
  logic [7:0] dig_n;
  logic       dp_n;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] e_seg [8];
  logic [7:0] e_dig [8];
  logic       e_dp  [8];
  logic       fd_first;
  logic [16:0] x_all;

  century_display_scan #(.SCAN_DIV(4), .BLANK_CYC(2)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_blank_lz   (blank_lz),
    .i_sec_unit   (sec_unit),
    .i_sec_ten    (sec_ten),
    .i_min_unit   (min_unit),
    .i_min_ten    (min_ten),
    .i_hour_unit  (hour_unit),
    .i_hour_ten   (hour_ten),
    .i_day_unit   (day_unit),
    .i_day_ten    (day_ten),
    .o_seg_n      (seg_n),
    .o_dig_n      (dig_n),
    .o_dp_n       (dp_n),
    .o_frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Expected frame image: slot s lit cycles are k = 6s+2 .. 6s+5 of the frame.
  function automatic logic [16:0] expect_at(input int k);
    int  s;
    logic lit;
    s   = k / 6;
    lit = (k % 6) >= 2;
    return {lit ? e_dig[s] : 8'hFF, lit ? e_seg[s] : 7'h7F,
            lit ? e_dp[s] : 1'b1, (k == 0) ? fd_first : 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_digits(input logic [3:0] su, st, mu, mt, hu, ht, du,
                            input logic [1:0] dt);
    logic [3:0] d [8];
    sec_unit = su; sec_ten = st; min_unit = mu; min_ten = mt;
    hour_unit = hu; hour_ten = ht; day_unit = du; day_ten = dt;
    d[0] = su; d[1] = st; d[2] = mu; d[3] = mt;
    d[4] = hu; d[5] = ht; d[6] = du; d[7] = {2'b00, dt};
    for (int s = 0; s < 8; s++) begin
      e_seg[s] = seg_of(d[s]);
      e_dig[s] = ~(8'h01 << s);
      e_dp[s]  = 1'b1;
    end
    e_dp[2] = su[0];
    e_dp[4] = su[0];
    if (blank_lz && dt == 2'd0) begin
      e_dig[7] = 8'hFF;
      e_seg[7] = 7'h7F;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; blank_lz = 1'b0;
    set_digits(4'd8, 4'd5, 4'd9, 4'd5, 4'd3, 4'd2, 4'd1, 2'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({dig_n, seg_n, dp_n, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL reset cyc%0d: dig=%h seg=%h dp=%b fd=%b, required FF 7F 1 0",
                 i, dig_n, seg_n, dp_n, frame_done);
      end
    end
    rst = 1'b0;
    fd_first = 1'b0;
  endtask

  task automatic test_static_scan();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 48; k++) begin
        x_all = expect_at(k);
        n_checks++;
        if ({dig_n, seg_n, dp_n, frame_done} !== x_all) begin
          n_fail++;
          $display("FAIL static f%0d k%0d: got %h %h %b %b, required %h %h %b %b", f, k,
                   dig_n, seg_n, dp_n, frame_done, x_all[16:9], x_all[8:2], x_all[1], x_all[0]);
        end
        step();
      end
      fd_first = 1'b1;
    end
  endtask

  task automatic test_coherency();
    set_digits(4'd8, 4'd5, 4'd9, 4'd5, 4'd3, 4'd2, 4'd1, 2'd3);
    for (int k = 0; k < 48; k++) begin
      x_all = expect_at(k);
      n_checks++;
      if ({dig_n, seg_n, dp_n, frame_done} !== x_all) begin
        n_fail++;
        $display("FAIL coherency_old k%0d: got %h %h %b %b, required %h %h %b %b", k,
                 dig_n, seg_n, dp_n, frame_done, x_all[16:9], x_all[8:2], x_all[1], x_all[0]);
      end
      if (k == 19) begin
        sec_unit = 0; sec_ten = 0; min_unit = 0; min_ten = 0;
        hour_unit = 0; hour_ten = 0; day_unit = 0; day_ten = 0;
      end
      step();
    end
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);
    for (int k = 0; k < 48; k++) begin
      x_all = expect_at(k);
      n_checks++;
      if ({dig_n, seg_n, dp_n, frame_done} !== x_all) begin
        n_fail++;
        $display("FAIL coherency_new k%0d: got %h %h %b %b, required %h %h %b %b", k,
                 dig_n, seg_n, dp_n, frame_done, x_all[16:9], x_all[8:2], x_all[1], x_all[0]);
      end
      step();
    end
  endtask

  task automatic test_invalid_bcd();
    set_digits(4'd8, 4'hC, 4'd9, 4'd5, 4'd3, 4'd2, 4'd1, 2'd3);
    for (int k = 0; k < 48; k++) begin
      x_all = expect_at(k);
      n_checks++;
      if ({dig_n, seg_n, dp_n, frame_done} !== x_all) begin
        n_fail++;
        $display("FAIL invalid_bcd k%0d: got %h %h %b %b, required %h %h %b %b", k,
                 dig_n, seg_n, dp_n, frame_done, x_all[16:9], x_all[8:2], x_all[1], x_all[0]);
      end
      step();
    end
  endtask

  task automatic test_leading_zero();
    for (int lz = 1; lz >= 0; lz--) begin
      blank_lz = lz[0];
      set_digits(4'd8, 4'd5, 4'd9, 4'd5, 4'd3, 4'd2, 4'd7, 2'd0);
      for (int k = 0; k < 48; k++) begin
        x_all = expect_at(k);
        n_checks++;
        if ({dig_n, seg_n, dp_n, frame_done} !== x_all) begin
          n_fail++;
          $display("FAIL leading_zero lz%0d k%0d: got %h %h %b %b, required %h %h %b %b", lz, k,
                   dig_n, seg_n, dp_n, frame_done, x_all[16:9], x_all[8:2], x_all[1], x_all[0]);
        end
        step();
      end
    end
  endtask

  task automatic test_mid_reset();
    set_digits(4'd8, 4'd5, 4'd9, 4'd5, 4'd3, 4'd2, 4'd1, 2'd3);
    for (int k = 0; k < 20; k++) step();
    rst = 1'b1;
    step();
    n_checks++;
    if ({dig_n, seg_n, dp_n, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset: dig=%h seg=%h dp=%b fd=%b, required FF 7F 1 0",
               dig_n, seg_n, dp_n, frame_done);
    end
    rst = 1'b0;
    fd_first = 1'b0;
    set_digits(4'd7, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd6, 2'd2);
    for (int k = 0; k < 48; k++) begin
      x_all = expect_at(k);
      n_checks++;
      if ({dig_n, seg_n, dp_n, frame_done} !== x_all) begin
        n_fail++;
        $display("FAIL after_reset k%0d: got %h %h %b %b, required %h %h %b %b", k,
                 dig_n, seg_n, dp_n, frame_done, x_all[16:9], x_all[8:2], x_all[1], x_all[0]);
      end
      step();
    end
    fd_first = 1'b1;
  endtask

  task automatic test_enable();
    set_digits(4'd8, 4'd5, 4'd9, 4'd5, 4'd3, 4'd2, 4'd1, 2'd3);
    for (int k = 0; k < 33; k++) begin
      x_all = expect_at(k);
      n_checks++;
      if ({dig_n, seg_n, dp_n, frame_done} !== x_all) begin
        n_fail++;
        $display("FAIL enable_pre k%0d: got %h %h %b %b, required %h %h %b %b", k,
                 dig_n, seg_n, dp_n, frame_done, x_all[16:9], x_all[8:2], x_all[1], x_all[0]);
      end
      step();
    end
    // Now inside slot 5's lit phase.
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({dig_n, seg_n, dp_n, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL enable_off cyc%0d: dig=%h seg=%h dp=%b fd=%b, required FF 7F 1 0",
                 i, dig_n, seg_n, dp_n, frame_done);
      end
    end
    set_digits(4'd7, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd6, 2'd2);
    en = 1'b1;
    fd_first = 1'b0;
    for (int k = 0; k < 48; k++) begin
      x_all = expect_at(k);
      n_checks++;
      if ({dig_n, seg_n, dp_n, frame_done} !== x_all) begin
        n_fail++;
        $display("FAIL enable_resume k%0d: got %h %h %b %b, required %h %h %b %b", k,
                 dig_n, seg_n, dp_n, frame_done, x_all[16:9], x_all[8:2], x_all[1], x_all[0]);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_static_scan();
    test_coherency();
    test_invalid_bcd();
    test_leading_zero();
    test_mid_reset();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/century_display_scan.md
Name: century_display_scan

Overview:
- Reader side of the century_clock digit bus.
- Takes the 8 BCD digits (sec/min/hour/day) and drives a multiplexed 8-digit common-anode 7-segment display.
- Snapshots all digits at each frame start, so a rollover never shows torn values.
- Adds anti-ghost blanking, day leading-zero blanking, invalid-BCD dash and a 1 Hz colon blink.

Parameters:
SCAN_DIV, 1000, clk cycles each digit is lit (>=1)
BLANK_CYC, 8, clk cycles all digits dark between slots (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  scan enable; 0 = display dark, scanner held at frame start
blank_lz  in  1  1 = suppress day_ten digit when it is 0
sec_unit  in  4  BCD
sec_ten  in  4  BCD
min_unit  in  4  BCD
min_ten  in  4  BCD
hour_unit  in  4  BCD
hour_ten  in  4  BCD
day_unit  in  4  BCD
day_ten  in  2  BCD, zero-extended to 4 bits internally
seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low
dig_n  out  8  digit enables, one-hot active-low; bit i = slot i
dp_n  out  1  decimal point/colon, active-low
frame_done  out  1  1-cycle pulse at end of each full frame

Behaviour:
- Slot order: 0 sec_unit, 1 sec_ten, 2 min_unit, 3 min_ten, 4 hour_unit, 5 hour_ten, 6 day_unit, 7 day_ten.
- Outputs are registered and update on the same edge as the FSM.
- Reset (rst=1 at posedge):
  - seg_n=7'h7F, dig_n=8'hFF, dp_n=1, frame_done=0.
  - state=BLANK, idx=0, cnt=0, snapshot=0.
  - Reset asserted mid-frame takes effect at the next edge, with no partial slot.
- FSM states BLANK and ON:
  - BLANK: dig_n=FF, seg_n=7F, dp_n=1 for exactly BLANK_CYC cycles, then go to ON.
  - ON: lit for exactly SCAN_DIV cycles, then go to BLANK with idx+1 (7 wraps to 0).
- Frame period is 8*(SCAN_DIV+BLANK_CYC) cycles.
- frame_done=1 for one cycle on the edge that leaves ON with idx=7.
- Snapshot: all 8 input digits are captured on the first cycle of BLANK with idx=0. Input changes at any other time are invisible until the next frame.
- ON drive:
  - dig_n = ~(1<<idx), seg_n = decode(snap[idx]).
  - Decode values: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10.
  - Any value >9 decodes to 3F (dash, g only).
- Leading zero: in slot 7, if blank_lz=1 and snap day_ten=0, then dig_n=FF and seg_n=7F. Slot timing is unchanged.
- Colon: in the ON phase of slots 2 and 4, dp_n = snap sec_unit[0] (lit on even seconds). dp_n=1 everywhere else.
- en=0 at an edge:
  - Next-cycle outputs equal the reset values (snapshot retained).
  - FSM forced to BLANK, idx=0, cnt=0.
  - When en returns to 1, a fresh snapshot is taken and slot 0 begins its full BLANK phase.
- Counter widths: $clog2 of max(SCAN_DIV, BLANK_CYC)+1. The counter is not free-running.

Decomposition:
- century_pkg holds:
  - NUM_DIGITS=8 and the slot index localparams (SLOT_SEC_U..SLOT_DAY_T).
  - The 7-segment active-low constants, including SEG_DASH=7'h3F and SEG_OFF=7'h7F.
  - The scan_state_t enum {BLANK, ON}.
- One sub-module: bcd_to_seg7, combinational, 4-bit in, 7-bit active-low out, dash for >9.

Test Plan:
- Reset: hold rst=1 for 3 cycles with en=1 → dig_n=FF, seg_n=7F, dp_n=1, frame_done=0 throughout.
- Static scan, SCAN_DIV=4, BLANK_CYC=2, time 23:59:58 day 31:
  - Slot 0: dig_n=FE, seg_n=00 for 4 cycles.
  - Slot 2: dig_n=FB, seg_n=10, dp_n=0.
  - Slot 7: dig_n=7F, seg_n=30.
  - Each slot is preceded by 2 dark cycles; frame_done pulses every 48 cycles.
- Coherency: change inputs 23:59:58→00:00:00 during slot 3 → rest of the frame still shows old digits; next frame shows new ones.
- Invalid BCD: sec_ten=4'hC → slot 1 shows seg_n=3F; other slots are unaffected.
- Leading zero, day=07:
  - blank_lz=1 → slot 7 dig_n=FF and seg_n=7F for its 4 cycles.
  - blank_lz=0 → dig_n=7F, seg_n=40.
- Enable:
  - Drop en during slot 5 → next cycle dig_n=FF, frame_done stays 0.
  - Raise en → 2 dark cycles, then slot 0 lit with freshly captured digits.
